alu_input_loader: RTL and testbench

Front-end sequencer that drives the combinational ALU from board switches and one push-button.
- Each debounced press captures the switch bank into the next operand register, in order A, B, operation.
- After the operation is captured, it samples the ALU result into a registered LED output.
- Sits between the board I/O pins and the ALU; owns all clocked state of the ALU datapath.

---
 rtl/alu_input_loader.sv | 136 +++++++++++++
 tb/tb_alu_input_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_input_loader.sv
// Sequencer between board I/O and the combinational ALU: debounced button presses load A, B, op; result is latched to LEDs.
// Optional macro LOADER_LIVE_RESULT_EN: o_leds follows i_result every clock instead of only in ST_RUN.
module alu_input_loader #(
  parameter int NB_DATA         = 4,
  parameter int NB_OP           = 6,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn,
  input  logic [NB_DATA-1:0] i_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_leds,
  output logic [1:0]         o_state,
  output logic               o_done
);

  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_A   = 2'd0,
    ST_B   = 2'd1,
    ST_OP  = 2'd2,
    ST_RUN = 2'd3
  } state_t;

  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              load_evt;

  state_t            state_q, state_d;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] leds_q, leds_d;
  logic               done_q, done_d;

  // Upper switch bits beyond the operand/opcode fields are intentionally ignored.
  logic unused_sw;
  assign unused_sw = ^i_sw;

  // Debounce: a new level must be seen DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + NB_CNT'(1);
      end
    end
  end

  // Event is asserted in the cycle whose closing edge raises the debounced level.
  assign load_evt = db_d & ~db_q;

  always_comb begin
    state_d  = state_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    op_d     = op_q;
    done_d   = 1'b0;
`ifdef LOADER_LIVE_RESULT_EN
    leds_d   = i_result;
`else
    leds_d   = leds_q;
`endif
    case (state_q)
      ST_A: begin
        if (load_evt) begin
          dato_a_d = i_sw[NB_DATA-1:0];
          state_d  = ST_B;
        end
      end
      ST_B: begin
        if (load_evt) begin
          dato_b_d = i_sw[NB_DATA-1:0];
          state_d  = ST_OP;
        end
      end
      ST_OP: begin
        if (load_evt) begin
          op_d    = i_sw[NB_OP-1:0];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        leds_d  = i_result;
        done_d  = 1'b1;
        state_d = ST_A;
      end
      default: state_d = ST_A;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_A;
      dato_a_q <= '0;
      dato_b_q <= '0;
      op_q     <= '0;
      leds_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= i_btn;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      op_q     <= op_d;
      leds_q   <= leds_d;
      done_q   <= done_d;
    end
  end

  assign o_datoA     = dato_a_q;
  assign o_datoB     = dato_b_q;
  assign o_operation = op_q;
  assign o_leds      = leds_q;
  assign o_state     = state_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Scoreboard bench for alu_input_loader: op presses queue the expected LED value, a monitor checks it on o_done.
module tb_alu_input_loader;

  logic       clk;
  logic       i_rst_n;
  logic [7:0] i_sw;
  logic       i_btn;
  logic [3:0] i_result;
  logic [3:0] o_datoA, o_datoB, o_leds;
  logic [5:0] o_operation;
  logic [1:0] o_state;
  logic       o_done;

  logic       force_en;
  logic [3:0] force_val;

  int n_checks;
  int n_pass;
  logic [3:0] exp_q[$];

  alu_input_loader #(
    .NB_DATA(4), .NB_OP(6), .NB_SW(8), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_sw(i_sw), .i_btn(i_btn), .i_result(i_result),
    .o_datoA(o_datoA), .o_datoB(o_datoB), .o_operation(o_operation),
    .o_leds(o_leds), .o_state(o_state), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driven by the DUT's operand registers.
  always_comb begin
    i_result = 4'h0;
    case (o_operation)
      6'b100000: i_result = o_datoA + o_datoB;
      6'b100010: i_result = o_datoA - o_datoB;
      6'b100100: i_result = o_datoA & o_datoB;
      6'b100101: i_result = o_datoA | o_datoB;
      6'b100110: i_result = o_datoA ^ o_datoB;
      6'b000011: i_result = 4'($signed(o_datoA) >>> o_datoB);
      6'b000010: i_result = o_datoA >> o_datoB;
      6'b100111: i_result = ~(o_datoA | o_datoB);
      default:   i_result = 4'h0;
    endcase
    if (force_en) i_result = force_val;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: every o_done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (o_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got o_leds=0x%0h expected no pulse", o_leds);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("leds_on_done", int'(o_leds), int'(e));
        $display("done: o_leds=0x%0h expected=0x%0h", o_leds, e);
      end
    end
  end

  task automatic press(input logic [7:0] sw);
    @(negedge clk);
    i_sw  = sw;
    i_btn = 1'b1;
    repeat (8) @(negedge clk);
    i_btn = 1'b0;
    repeat (8) @(negedge clk);
    $display("press sw=0x%02h -> state=%0d A=0x%0h B=0x%0h op=0x%02h", sw, o_state, o_datoA, o_datoB, o_operation);
  endtask

  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [3:0] exp_leds);
    press(a);
    press(b);
    exp_q.push_back(exp_leds);
    press(op);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass = 0;
    i_rst_n = 1'b0;
    i_sw = 8'h00;
    i_btn = 1'b0;
    force_en = 1'b0;
    force_val = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_state", int'(o_state), 0);
    check("reset_outs", int'({o_datoA, o_datoB, o_operation, o_leds, o_done}), 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ADD sequence
    run_seq(8'h03, 8'h05, 8'h20, 4'h8);
    check("s1_A", int'(o_datoA), 3);
    check("s1_B", int'(o_datoB), 5);
    check("s1_op", int'(o_operation), 6'b100000);
    check("s1_state", int'(o_state), 0);

    run_seq(8'h03, 8'h05, 8'h22, 4'hE);

    // Short glitch must not load
    @(negedge clk);
    i_sw = 8'h0C;
    i_btn = 1'b1;
    repeat (2) @(negedge clk);
    i_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("s2_state", int'(o_state), 0);
    check("s2_A", int'(o_datoA), 3);

    // Long hold gives exactly one event
    i_sw = 8'h09;
    i_btn = 1'b1;
    repeat (100) @(negedge clk);
    check("s3_state_held", int'(o_state), 1);
    check("s3_A", int'(o_datoA), 9);
    i_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("s3_state_rel", int'(o_state), 1);
    press(8'h06);
    exp_q.push_back(4'h0);
    press(8'h24);

    // Upper switch bits ignored
    run_seq(8'hF7, 8'h01, 8'h20, 4'h8);
    check("s4_A_trunc", int'(o_datoA), 7);
    run_seq(8'h18, 8'hA2, 8'hC2, 4'h2);
    check("s4_op_trunc", int'(o_operation), 6'b000010);
    run_seq(8'h05, 8'h03, 8'h3F, 4'h0);
    check("s4_undef_op", int'(o_operation), 6'h3F);
    run_seq(8'h0C, 8'h0A, 8'h26, 4'h6);

    // Async reset mid-sequence
    press(8'h01);
    press(8'h02);
    check("s5_pre_state", int'(o_state), 2);
    #2 i_rst_n = 1'b0;
    #1;
    check("s5_async_state", int'(o_state), 0);
    check("s5_async_outs", int'({o_datoA, o_datoB, o_operation, o_leds, o_done}), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(8'h0B);
    check("s5_A_after", int'(o_datoA), 4'hB);
    check("s5_state_after", int'(o_state), 1);
    press(8'h04);
    exp_q.push_back(4'hF);
    press(8'h25);

    // Forced ALU result while idle
    force_val = 4'hA;
    force_en = 1'b1;
    @(negedge clk);
`ifdef LOADER_LIVE_RESULT_EN
    check("s6_leds", int'(o_leds), 4'hA);
`else
    check("s6_leds", int'(o_leds), 4'hF);
`endif
    check("s6_done", int'(o_done), 0);
    force_en = 1'b0;
    repeat (3) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
